// File: rtl/gsim_ctrl.sv
// gsim_ctrl: sequencing controller for the GSIM solver datapath.
//
// It loads N right-hand-side values b[]. It then issues one row per cycle to an
// external PE for ITER sweeps and writes each PE result back into x[] in place.
// Finally it streams x[0..N-1] out.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-low; clears every register
//   in_en      b_in valid (only honoured while loading)
//   b_in       signed integer b value
//   out_valid  x_out valid, high for N consecutive cycles per solve
//   x_out      signed Q16.16 x[k], k = 0..N-1 in order
//   pe_b       b[row] of the row being issued
//   pe_in1..6  x[row-3], x[row+3], x[row-2], x[row+2], x[row-1], x[row+1]
//   pe_out     PE result for the row issued PE_LAT cycles earlier
module gsim_ctrl #(
    parameter int N      = 16,   // power of two, at least 4
    parameter int ITER   = 64,
    parameter int PE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    output logic        out_valid,
    output logic [31:0] x_out,
    output logic [15:0] pe_b,
    output logic [31:0] pe_in1,
    output logic [31:0] pe_in2,
    output logic [31:0] pe_in3,
    output logic [31:0] pe_in4,
    output logic [31:0] pe_in5,
    output logic [31:0] pe_in6,
    input  logic [31:0] pe_out
);
    localparam int IW   = $clog2(N);
    localparam int IT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int DW   = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN, OUT} state_t;

    state_t state_reg, state_next;

    logic [IW-1:0]   ld_idx_reg;
    logic [IW-1:0]   row_reg;
    logic [IW-1:0]   k_reg;
    logic [IT_W-1:0] iter_reg;
    logic [DW-1:0]   drain_reg;

    // x[] and b[] are flat register files rather than RAM.
    // Each cycle needs seven concurrent reads, a write-back, and a one-cycle bulk clear of x[].
    logic [15:0] b_reg [N];
    logic [31:0] x_reg [N];

    // Write-back delay line: marks which row's result is currently on pe_out.
    logic [PE_LAT-1:0]         dl_valid_reg;
    logic [PE_LAT-1:0][IW-1:0] dl_idx_reg;

    logic last_load, last_row, sweep_done, last_drain, last_out;

    assign last_load  = in_en && (ld_idx_reg == IW'(N - 1));
    assign last_row   = (row_reg == IW'(N - 1));
    assign sweep_done = last_row && (iter_reg == IT_W'(ITER - 1));
    assign last_drain = (drain_reg == DW'(PE_LAT - 1));
    assign last_out   = (k_reg == IW'(N - 1));

    // Neighbour operands. Entry gi is offset -3,+3,-2,+2,-1,+1 from the row being issued.
    // pos is widened by two bits. With N >= 4, the top two bits are both zero exactly
    // when the neighbour lies inside 0..N-1. This covers both the negative wrap and >= N.
    logic [5:0][31:0] nb_val;

    for (genvar gi = 0; gi < 6; gi++) begin : g_nb
        localparam int DIST = 3 - gi / 2;
        localparam int OFS  = (gi % 2 == 0) ? -DIST : DIST;
        logic [IW+1:0] pos;
        assign pos        = {2'b00, row_reg} + (IW+2)'(OFS);
        assign nb_val[gi] = (state_reg == RUN && pos[IW+1:IW] == 2'b00) ? x_reg[pos[IW-1:0]] : '0;
    end

    assign pe_in1 = nb_val[0];
    assign pe_in2 = nb_val[1];
    assign pe_in3 = nb_val[2];
    assign pe_in4 = nb_val[3];
    assign pe_in5 = nb_val[4];
    assign pe_in6 = nb_val[5];

    always_comb begin
        state_next = state_reg;
        out_valid  = 1'b0;
        x_out      = '0;
        pe_b       = '0;
        case (state_reg)
            LOAD: begin
                if (last_load) state_next = RUN;
            end
            RUN: begin
                pe_b = b_reg[row_reg];
                if (sweep_done) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_drain) state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                x_out     = x_reg[k_reg];
                if (last_out) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= LOAD;
            ld_idx_reg <= '0;
            row_reg    <= '0;
            k_reg      <= '0;
            iter_reg   <= '0;
            drain_reg  <= '0;
            for (int i = 0; i < N; i++) b_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD: begin
                    if (in_en) begin
                        b_reg[ld_idx_reg] <= b_in;
                        ld_idx_reg        <= ld_idx_reg + 1'b1;
                        if (last_load) begin
                            row_reg  <= '0;
                            iter_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    // Row wraps N-1 -> 0 naturally; sweeps run back to back with no bubble.
                    row_reg <= row_reg + 1'b1;
                    if (last_row) iter_reg <= sweep_done ? '0 : iter_reg + 1'b1;
                end
                DRAIN: begin
                    drain_reg <= last_drain ? '0 : drain_reg + 1'b1;
                end
                OUT: begin
                    k_reg <= k_reg + 1'b1;
                    if (last_out) ld_idx_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    // Results are committed at the end of the cycle in which they sit on pe_out.
    // So a row sees a result only when it is issued PE_LAT+1 or more cycles after the producing row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_valid_reg <= '0;
            dl_idx_reg   <= '0;
            for (int i = 0; i < N; i++) x_reg[i] <= '0;
        end else begin
            for (int i = PE_LAT - 1; i > 0; i--) begin
                dl_valid_reg[i] <= dl_valid_reg[i-1];
                dl_idx_reg[i]   <= dl_idx_reg[i-1];
            end
            dl_valid_reg[0] <= (state_reg == RUN);
            dl_idx_reg[0]   <= row_reg;
            if (state_reg == OUT && last_out) begin
                for (int i = 0; i < N; i++) x_reg[i] <= '0;
            end else if (dl_valid_reg[PE_LAT-1]) begin
                x_reg[dl_idx_reg[PE_LAT-1]] <= pe_out;
            end
        end
    end

endmodule

// File: tb/tb_gsim_ctrl.sv
// Testbench for gsim_ctrl.
// Two instances are used: dut_a runs the full 64 sweeps and dut_b runs a single sweep.
// Each instance has a behavioural PE with PE_LAT cycles of latency. The expected x[]
// comes from a sequential model: issue t sees the results of all issues up to t-PE_LAT-1.
module tb_gsim_ctrl;
    localparam int N      = 16;
    localparam int PE_LAT = 2;
    localparam int ITER_A = 64;
    localparam int ITER_B = 1;

    typedef logic [15:0] bvec_t [N];
    typedef logic [31:0] xvec_t [N];

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic        in_en_a, in_en_b;
    logic [15:0] b_in_a, b_in_b;
    logic        ov_a, ov_b;
    logic [31:0] xo_a, xo_b;
    logic [15:0] pe_b_a, pe_b_b;
    logic [31:0] pa1, pa2, pa3, pa4, pa5, pa6;
    logic [31:0] pb1, pb2, pb3, pb4, pb5, pb6;
    logic [31:0] pe_out_a, pe_out_b;
    logic [31:0] pipe_a [PE_LAT];
    logic [31:0] pipe_b [PE_LAT];
    logic [31:0] pe_or_a, pe_or_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gsim_ctrl #(.N(N), .ITER(ITER_A), .PE_LAT(PE_LAT)) dut_a (
        .clk(clk), .reset(reset), .in_en(in_en_a), .b_in(b_in_a),
        .out_valid(ov_a), .x_out(xo_a), .pe_b(pe_b_a),
        .pe_in1(pa1), .pe_in2(pa2), .pe_in3(pa3), .pe_in4(pa4), .pe_in5(pa5), .pe_in6(pa6),
        .pe_out(pe_out_a)
    );

    gsim_ctrl #(.N(N), .ITER(ITER_B), .PE_LAT(PE_LAT)) dut_b (
        .clk(clk), .reset(reset), .in_en(in_en_b), .b_in(b_in_b),
        .out_valid(ov_b), .x_out(xo_b), .pe_b(pe_b_b),
        .pe_in1(pb1), .pe_in2(pb2), .pe_in3(pb3), .pe_in4(pb4), .pe_in5(pb5), .pe_in6(pb6),
        .pe_out(pe_out_b)
    );

    assign pe_or_a = {16'h0, pe_b_a} | pa1 | pa2 | pa3 | pa4 | pa5 | pa6;
    assign pe_or_b = {16'h0, pe_b_b} | pb1 | pb2 | pb3 | pb4 | pb5 | pb6;

    // (b*2^16 + (m3+p3) - 6(m2+p2) + 13(m1+p1)) / 20, truncating, kept to 32 bits.
    function automatic logic [31:0] pe_calc(input logic [15:0] b,
                                            input logic [31:0] m3, input logic [31:0] p3,
                                            input logic [31:0] m2, input logic [31:0] p2,
                                            input logic [31:0] m1, input logic [31:0] p1);
        longint s;
        s = longint'($signed(b)) * 65536
          + longint'($signed(m3)) + longint'($signed(p3))
          - 6 * (longint'($signed(m2)) + longint'($signed(p2)))
          + 13 * (longint'($signed(m1)) + longint'($signed(p1)));
        return 32'(s / 20);
    endfunction

    always @(posedge clk) begin
        pipe_a[0] <= pe_calc(pe_b_a, pa1, pa2, pa3, pa4, pa5, pa6);
        pipe_b[0] <= pe_calc(pe_b_b, pb1, pb2, pb3, pb4, pb5, pb6);
        for (int i = 1; i < PE_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign pe_out_a = pipe_a[PE_LAT-1];
    assign pe_out_b = pipe_b[PE_LAT-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nbx(input xvec_t xa, input int j);
        return (j >= 0 && j < N) ? xa[j] : 32'h0;
    endfunction

    // Issue-order model: before issue t is computed, the result of issue t-PE_LAT-1 is committed.
    task automatic ref_model(input bvec_t bv, input int iters, output xvec_t xr);
        xvec_t       x;
        logic [31:0] res [$];
        int          total;
        int          first_left;
        total = iters * N;
        for (int j = 0; j < N; j++) x[j] = 32'h0;
        for (int t = 0; t < total; t++) begin
            int r;
            r = t % N;
            if (t >= PE_LAT + 1) x[(t - PE_LAT - 1) % N] = res[t - PE_LAT - 1];
            res.push_back(pe_calc(bv[r], nbx(x, r - 3), nbx(x, r + 3), nbx(x, r - 2),
                                  nbx(x, r + 2), nbx(x, r - 1), nbx(x, r + 1)));
        end
        first_left = (total > PE_LAT + 1) ? total - PE_LAT - 1 : 0;
        for (int t = first_left; t < total; t++) x[t % N] = res[t];
        xr = x;
    endtask

    function automatic logic ov_sel(input bit sel);
        return sel ? ov_b : ov_a;
    endfunction

    function automatic logic [31:0] xo_sel(input bit sel);
        return sel ? xo_b : xo_a;
    endfunction

    task automatic drive(input bit sel, input logic en, input logic [15:0] b);
        if (sel) begin
            in_en_b = en;
            b_in_b  = b;
        end else begin
            in_en_a = en;
            b_in_a  = b;
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first RUN cycle.
    task automatic load_only(input bit sel, input bvec_t bv, input int max_gap, output int pres_cyc);
        pres_cyc = 0;
        for (int i = 0; i < N; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                drive(sel, 1'b0, 16'($urandom));
                @(negedge clk);
            end
            drive(sel, 1'b1, bv[i]);
            pres_cyc = cyc;
            @(negedge clk);
        end
        drive(sel, 1'b0, 16'h0);
    endtask

    task automatic collect(input bit sel, input int iters, input bit junk, input int pres_cyc,
                           output xvec_t got, output int lat);
        int waited;
        bit seen;
        seen   = 1'b0;
        waited = 0;
        lat    = -1;
        for (int k = 0; k < N; k++) got[k] = 32'h0;
        while (!seen && waited < iters * N + 64) begin
            if (ov_sel(sel)) begin
                seen = 1'b1;
            end else begin
                if (junk) drive(sel, 1'($urandom), 16'($urandom));
                @(negedge clk);
                waited++;
            end
        end
        check_val("ov_rise", 32'(seen), 32'd1);
        if (seen) begin
            lat = cyc - pres_cyc;
            for (int k = 0; k < N; k++) begin
                check_val($sformatf("ov_hi%0d", k), 32'(ov_sel(sel)), 32'd1);
                got[k] = xo_sel(sel);
                if (junk && k < N - 1) drive(sel, 1'($urandom), 16'($urandom));
                else drive(sel, 1'b0, 16'h0);
                @(negedge clk);
            end
            check_val("ov_fall", 32'(ov_sel(sel)), 32'd0);
            check_val("xo_idle", xo_sel(sel), 32'h0);
        end
        drive(sel, 1'b0, 16'h0);
        $display("system dut_%s lat=%0d x0=0x%08h", sel ? "b" : "a", lat, got[0]);
    endtask

    task automatic cmp_model(input string tag, input xvec_t got, input xvec_t exp);
        for (int k = 0; k < N; k++) check_val($sformatf("%s_x%0d", tag, k), got[k], exp[k]);
    endtask

    initial begin
        bvec_t bv_t2, bv;
        xvec_t got, exp_t2, exp;
        int    pres, lat;

        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        check_val("rst_ov_a", 32'(ov_a), 32'd0);
        check_val("rst_xo_a", xo_a, 32'h0);
        check_val("rst_pe_a", pe_or_a, 32'h0);
        check_val("rst_ov_b", 32'(ov_b), 32'd0);
        check_val("rst_pe_b", pe_or_b, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // All-zero b, full ITER: latency and all-zero result.
        for (int k = 0; k < N; k++) bv[k] = 16'h0;
        load_only(1'b0, bv, 0, pres);
        collect(1'b0, ITER_A, 1'b0, pres, got, lat);
        check_val("t1_lat", 32'(lat), 32'(ITER_A * N + PE_LAT + 1));
        for (int k = 0; k < N; k++) check_val($sformatf("t1_x%0d", k), got[k], 32'h0);

        // Single sweep with b[0]=20: known closed-form values plus model.
        for (int k = 0; k < N; k++) bv_t2[k] = 16'h0;
        bv_t2[0] = 16'd20;
        ref_model(bv_t2, ITER_B, exp_t2);
        load_only(1'b1, bv_t2, 0, pres);
        collect(1'b1, ITER_B, 1'b0, pres, got, lat);
        check_val("t2_lat", 32'(lat), 32'(ITER_B * N + PE_LAT + 1));
        check_val("t2_k0", got[0], 32'h0001_0000);
        check_val("t2_k1", got[1], 32'h0);
        check_val("t2_k2", got[2], 32'h0);
        check_val("t2_k3", got[3], 32'h0000_0CCC);
        check_val("t2_k4", got[4], 32'h0);
        check_val("t2_k5", got[5], 32'h0);
        check_val("t2_k6", got[6], 32'h0000_00A3);
        cmp_model("t2", got, exp_t2);

        // Same stream with random gaps: identical results and issue-to-output latency.
        load_only(1'b1, bv_t2, 5, pres);
        collect(1'b1, ITER_B, 1'b0, pres, got, lat);
        check_val("t3_lat", 32'(lat), 32'(ITER_B * N + PE_LAT + 1));
        cmp_model("t3", got, exp_t2);

        // Random b with junk in_en pulses during RUN/DRAIN/OUT.
        for (int k = 0; k < N; k++) bv[k] = 16'($urandom);
        ref_model(bv, ITER_A, exp);
        load_only(1'b0, bv, 2, pres);
        collect(1'b0, ITER_A, 1'b1, pres, got, lat);
        cmp_model("t4", got, exp);

        // Loaded immediately after the previous OUT: index 0 again, x[] cleared.
        for (int k = 0; k < N; k++) bv[k] = 16'($urandom);
        ref_model(bv, ITER_A, exp);
        load_only(1'b0, bv, 0, pres);
        collect(1'b0, ITER_A, 1'b0, pres, got, lat);
        check_val("t6_lat", 32'(lat), 32'(ITER_A * N + PE_LAT + 1));
        cmp_model("t6", got, exp);

        // Partial load on dut_b, dut_a mid-RUN, then asynchronous reset.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 16'($urandom));
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < N; k++) bv[k] = 16'($urandom);
        load_only(1'b0, bv, 0, pres);
        repeat (200) @(negedge clk);
        check_val("t5_row", {16'h0, pe_b_a}, {16'h0, bv[200 % N]});
        reset = 1'b0;
        #1;
        check_val("t5_rst_ov", 32'(ov_a), 32'd0);
        check_val("t5_rst_pe", pe_or_a, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) bv[k] = 16'($urandom);
        ref_model(bv, ITER_A, exp);
        load_only(1'b0, bv, 1, pres);
        collect(1'b0, ITER_A, 1'b0, pres, got, lat);
        cmp_model("t5", got, exp);
        load_only(1'b1, bv_t2, 0, pres);
        collect(1'b1, ITER_B, 1'b0, pres, got, lat);
        cmp_model("t5b", got, exp_t2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
